// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Constants and types shared by the 4-bit PRBS generator and the stream
// checker, so that both ends use the same feedback polynomial.
//   LFSR_WIDTH   : LFSR length (also history / word width)
//   LFSR_TAPS    : feedback mask over the history, bit 0 = newest bit.
//                  4'b1100 gives b[n] = b[n-3] ^ b[n-4].
//   lfsr_state_e : checker synchronisation states
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package lfsr_pkg;

    localparam int LFSR_WIDTH = 4;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 4'b1100;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lfsr_state_e;

endpackage

// File: rtl/lfsr_err_counter.sv
// -----------------------------------------------------------------------------
// lfsr_err_counter
// Saturating up-counter with synchronous clear. Clear has priority over
// increment; once all-ones the count holds.
//   clk    in   clock, rising edge
//   rst_i  in   asynchronous active-high reset
//   clr_i  in   synchronous clear
//   inc_i  in   increment enable
//   cnt_o  out  CNT_W-bit count
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module lfsr_err_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/lfsr_stream_checker.sv
// -----------------------------------------------------------------------------
// lfsr_stream_checker
// Self-synchronising checker for the serial PRBS stream of the LFSR
// generator. The received bit is always shifted into the history, so after
// WIDTH clean bits the predictor is back in step with the generator. Lock is
// declared after LOCK_CNT consecutive correct predictions and dropped after
// LOSS_CNT consecutive mispredictions. The stream is also repacked into
// WIDTH-bit words.
//   clk        in   clock, rising edge
//   rest       in   asynchronous active-high reset
//   in_bit     in   serial PRBS bit
//   in_vld     in   qualifies in_bit
//   clr_cnt    in   synchronous clear of err_cnt
//   word       out  last WIDTH accepted bits, MSB oldest
//   word_vld   out  one-cycle strobe every WIDTH accepted bits
//   locked     out  checker is locked
//   err_pulse  out  one-cycle strobe per mismatch while locked
//   err_cnt    out  saturating locked-mode mismatch count
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module lfsr_stream_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS     = LFSR_TAPS,
    parameter int               LOCK_CNT = 4,
    parameter int               LOSS_CNT = 3,
    parameter int               CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             in_bit,
    input  logic             in_vld,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] word,
    output logic             word_vld,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int POS_W   = $clog2(WIDTH);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(WIDTH - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_CNT - 1);

    lfsr_state_e        state_q, state_d;
    logic [WIDTH-1:0]   hist_q, hist_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic               word_vld_q, word_vld_d;
    logic               err_pulse_q, err_pulse_d;
    logic [POS_W-1:0]   fill_q, fill_d;
    logic [POS_W-1:0]   wcnt_q, wcnt_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MISS_W-1:0]  miss_q, miss_d;

    logic pred;
    logic bit_ok;
    logic err_inc;

    // Prediction uses the history before this bit is shifted in. An all-zero
    // history is the LFSR lock-up state and must never count as a good match.
    assign pred   = ^(hist_q & TAPS);
    assign bit_ok = (in_bit == pred) && (hist_q != '0);

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        word_d      = word_q;
        word_vld_d  = 1'b0;
        err_pulse_d = 1'b0;
        fill_d      = fill_q;
        wcnt_d      = wcnt_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_inc     = 1'b0;

        if (in_vld) begin
            hist_d = {hist_q[WIDTH-2:0], in_bit};

            if (wcnt_q == POS_LAST) begin
                wcnt_d     = '0;
                word_d     = hist_d;
                word_vld_d = 1'b1;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end

            case (state_q)
                FILL: begin
                    if (fill_q == POS_LAST) begin
                        fill_d  = '0;
                        match_d = '0;
                        state_d = CHECK;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (!bit_ok) begin
                        match_d = '0;
                    end else if (match_q == MATCH_LAST) begin
                        match_d = '0;
                        miss_d  = '0;
                        state_d = LOCKED;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (bit_ok) begin
                        miss_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        if (miss_q == MISS_LAST) begin
                            // Resync: history is kept, word framing restarts.
                            miss_d  = '0;
                            match_d = '0;
                            wcnt_d  = '0;
                            state_d = CHECK;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state_q     <= FILL;
            hist_q      <= '0;
            word_q      <= '0;
            word_vld_q  <= 1'b0;
            err_pulse_q <= 1'b0;
            fill_q      <= '0;
            wcnt_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            word_q      <= word_d;
            word_vld_q  <= word_vld_d;
            err_pulse_q <= err_pulse_d;
            fill_q      <= fill_d;
            wcnt_q      <= wcnt_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
        end
    end

    lfsr_err_counter #(
        .CNT_W (CNT_W)
    ) u_err_counter (
        .clk   (clk),
        .rst_i (rest),
        .clr_i (clr_cnt),
        .inc_i (err_inc),
        .cnt_o (err_cnt)
    );

    assign word      = word_q;
    assign word_vld  = word_vld_q;
    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
`timescale 1ns/1ps
module tb_lfsr_stream_checker;

    logic       clk = 1'b0;
    logic       rest;
    logic       in_bit;
    logic       in_vld;
    logic       clr_cnt;
    logic [3:0] word;
    logic       word_vld;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    lfsr_stream_checker dut (
        .clk       (clk),
        .rest      (rest),
        .in_bit    (in_bit),
        .in_vld    (in_vld),
        .clr_cnt   (clr_cnt),
        .word      (word),
        .word_vld  (word_vld),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // History kept as a list of the last four accepted bits, oldest first.
    bit         mh[$];
    int         m_phase;   // 0 filling, 1 checking, 2 locked
    int         m_fill;
    int         m_match;
    int         m_miss;
    int         m_wcnt;
    int         m_err;
    logic [3:0] m_word;
    bit         m_wvld;
    bit         m_epulse;

    bit         ref_seq[15];
    int         ph;
    string      seg;
    logic [3:0] cap_q[$];

    task automatic model_reset();
        mh = {1'b0, 1'b0, 1'b0, 1'b0};
        m_phase = 0; m_fill = 0; m_match = 0; m_miss = 0;
        m_wcnt = 0; m_err = 0; m_word = 4'd0; m_wvld = 0; m_epulse = 0;
    endtask

    // b[n] = b[n-3] ^ b[n-4]
    function automatic bit m_pred();
        return mh[0] ^ mh[1];
    endfunction

    task automatic model_step(input bit b, input bit v, input bit c);
        bit good;
        bit err_now;
        err_now  = 0;
        m_wvld   = 0;
        m_epulse = 0;
        if (v) begin
            good = (b == m_pred()) && ((mh[0] | mh[1] | mh[2] | mh[3]) != 1'b0);
            void'(mh.pop_front());
            mh.push_back(b);
            m_wcnt = (m_wcnt + 1) % 4;
            if (m_wcnt == 0) begin
                m_word = {mh[0], mh[1], mh[2], mh[3]};
                m_wvld = 1;
            end
            if (m_phase == 0) begin
                m_fill++;
                if (m_fill == 4) begin m_phase = 1; m_match = 0; end
            end else if (m_phase == 1) begin
                m_match = good ? m_match + 1 : 0;
                if (m_match == 4) begin m_phase = 2; m_miss = 0; end
            end else begin
                if (good) begin
                    m_miss = 0;
                end else begin
                    err_now  = 1;
                    m_epulse = 1;
                    m_miss++;
                    if (m_miss == 3) begin m_phase = 1; m_match = 0; m_wcnt = 0; end
                end
            end
        end
        if (c) m_err = 0;
        else if (err_now && m_err < 255) m_err++;
    endtask

    task automatic check_outputs();
        check_val({seg, ".word"},      int'(word),      int'(m_word));
        check_val({seg, ".word_vld"},  int'(word_vld),  int'(m_wvld));
        check_val({seg, ".locked"},    int'(locked),    (m_phase == 2) ? 1 : 0);
        check_val({seg, ".err_pulse"}, int'(err_pulse), int'(m_epulse));
        check_val({seg, ".err_cnt"},   int'(err_cnt),   m_err);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".word0"},      int'(word),      0);
        check_val({tag, ".word_vld0"},  int'(word_vld),  0);
        check_val({tag, ".locked0"},    int'(locked),    0);
        check_val({tag, ".err_pulse0"}, int'(err_pulse), 0);
        check_val({tag, ".err_cnt0"},   int'(err_cnt),   0);
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle(input bit b, input bit v, input bit c);
        in_bit  = b;
        in_vld  = v;
        clr_cnt = c;
        @(posedge clk);
        #1;
        model_step(b, v, c);
        check_outputs();
        if (word_vld) cap_q.push_back(word);
        if (v) $display("%s: bit=%0d clr=%0d word=%h word_vld=%0d locked=%0d err_pulse=%0d err_cnt=%0d",
                        seg, b, c, word, word_vld, locked, err_pulse, err_cnt);
    endtask

    task automatic feed(input int n, input int gap_pct, input int flip_at);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++)
                cycle(bit'($urandom_range(1)), 1'b0, 1'b0);
            cycle(ref_seq[ph] ^ (i == flip_at), 1'b1, 1'b0);
            ph = (ph + 1) % 15;
        end
    endtask

    task automatic do_reset(input string tag, input int hold_ns);
        in_vld  = 1'b0;
        clr_cnt = 1'b0;
        in_bit  = 1'b0;
        #2 rest = 1'b1;
        #1 check_zero(tag);
        #(hold_ns) rest = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        ph = 0;
        cap_q.delete();
    endtask

    task automatic check_words(input string tag);
        int exp_w[3];
        exp_w = '{7, 8, 9};
        for (int k = 0; k < 3; k++)
            check_val({tag, ".first_words"}, (k < cap_q.size()) ? int'(cap_q[k]) : -1, exp_w[k]);
    endtask

    initial begin
        ref_seq = '{0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1};
        rest    = 1'b1;
        in_bit  = 1'b0;
        in_vld  = 1'b0;
        clr_cnt = 1'b0;
        ph      = 0;
        @(posedge clk);
        #1;
        model_reset();
        seg = "reset";
        check_outputs();
        do_reset("reset", 10);

        // Clean stream, three periods
        seg = "clean";
        for (int i = 0; i < 45; i++) begin
            cycle(ref_seq[ph], 1'b1, 1'b0);
            ph = (ph + 1) % 15;
            if (i == 6) check_val("clean.locked_bit7", int'(locked), 0);
            if (i == 7) check_val("clean.locked_bit8", int'(locked), 1);
        end
        check_words("clean");
        check_val("clean.err_cnt_end", int'(err_cnt), 0);

        // Same stream with random 50% gaps
        do_reset("gap_rst", 10);
        seg = "gapped";
        feed(45, 50, -1);
        check_words("gapped");
        check_val("gapped.locked_end", int'(locked), 1);
        check_val("gapped.err_cnt_end", int'(err_cnt), 0);

        // Single flipped bit 20
        do_reset("flip_rst", 10);
        seg = "flip";
        feed(30, 0, 19);
        check_val("flip.err_cnt", int'(err_cnt), 3);
        check_val("flip.locked", int'(locked), 1);

        // Constant zero stream
        do_reset("zero_rst", 10);
        seg = "zeros";
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 1'b0);
        check_val("zeros.locked", int'(locked), 0);
        check_val("zeros.err_cnt", int'(err_cnt), 0);

        // Three forced mispredictions, then a different phase
        do_reset("resync_rst", 10);
        seg = "resync";
        feed(12, 0, -1);
        for (int k = 0; k < 3; k++) begin
            cycle(~m_pred(), 1'b1, 1'b0);
            if (k == 1) check_val("resync.locked_after2", int'(locked), 1);
            if (k == 2) check_val("resync.locked_after3", int'(locked), 0);
        end
        ph = (ph + 6) % 15;
        feed(12, 0, -1);
        check_val("resync.relocked", int'(locked), 1);

        // Saturation: one flipped bit every six gives three errors each
        do_reset("sat_rst", 10);
        seg = "sat";
        feed(10, 0, -1);
        for (int g = 0; g < 90; g++) feed(6, 0, 0);
        check_val("sat.err_cnt", int'(err_cnt), 255);
        check_val("sat.locked", int'(locked), 1);

        // Clear together with an error
        seg = "clr";
        cycle(~ref_seq[ph], 1'b1, 1'b1);
        ph = (ph + 1) % 15;
        check_val("clr.err_cnt", int'(err_cnt), 0);
        check_val("clr.err_pulse", int'(err_pulse), 1);
        feed(8, 0, -1);

        // Random stream: random valid, occasional bit errors and clears
        seg = "random";
        for (int i = 0; i < 300; i++) begin
            bit v;
            bit c;
            bit b;
            v = bit'($urandom_range(1));
            c = ($urandom_range(49) == 0);
            b = ref_seq[ph] ^ ($urandom_range(19) == 0);
            cycle(b, v, c);
            if (v) ph = (ph + 1) % 15;
        end

        // Long asynchronous reset in the middle of a locked stream
        seg = "areset";
        feed(10, 0, -1);
        do_reset("areset", 1300);
        ph = $urandom_range(14);
        feed(8, 0, -1);
        check_val("areset.relock8", int'(locked), 1);
        check_val("areset.err_cnt", int'(err_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
